// File: rtl/ped_crossing_ctrl.sv
// Pedestrian-crossing controller that follows an upstream red/yellow/green light.
// Grants WALK at the start of a red phase, then a flashing don't-walk, and flags illegal lamp patterns.
module ped_crossing_ctrl #(
  parameter int WALK_CYCLES  = 20,
  parameter int FLASH_CYCLES = 10,
  parameter int BLINK_HALF   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       red,
  input  logic       yellow,
  input  logic       green,
  input  logic       ped_btn,
  output logic       walk,
  output logic       dont_walk,
  output logic       ped_pending,
  output logic [7:0] countdown,
  output logic       fault
);

  typedef enum logic [1:0] {IDLE, WALK, FLASH, FAULT} state_t;

  localparam int         BW          = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [7:0] CROSS_TOTAL = 8'(WALK_CYCLES + FLASH_CYCLES);
  localparam logic [7:0] WALK_LAST   = 8'(FLASH_CYCLES + 1);

  state_t        state;
  logic          red_q;
  logic          btn_q;
  logic          armed;
  logic          illegal_q;
  logic [BW-1:0] blink_cnt;

  logic legal;
  logic red_start;
  logic btn_rise;

  assign legal     = $onehot({red, yellow, green});
  assign red_start = red & ~red_q;
  assign btn_rise  = ped_btn & ~btn_q;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      walk        <= 1'b0;
      dont_walk   <= 1'b1;
      ped_pending <= 1'b0;
      countdown   <= '0;
      fault       <= 1'b0;
      red_q       <= 1'b0;
      btn_q       <= 1'b0;
      armed       <= 1'b0;
      illegal_q   <= 1'b0;
      blink_cnt   <= '0;
    end else begin
      red_q     <= red;
      btn_q     <= ped_btn;
      armed     <= armed | legal;
      illegal_q <= ~legal;

      // Two consecutive illegal samples after arming; outranks every other transition.
      if (state != FAULT && armed && !legal && illegal_q) begin
        state       <= FAULT;
        fault       <= 1'b1;
        walk        <= 1'b0;
        dont_walk   <= 1'b1;
        ped_pending <= 1'b0;
        countdown   <= '0;
        blink_cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            // ped_pending is the pre-edge value, so a press on the red-start edge waits a full cycle of lights.
            if (red_start && ped_pending) begin
              state       <= WALK;
              walk        <= 1'b1;
              dont_walk   <= 1'b0;
              countdown   <= CROSS_TOTAL;
              ped_pending <= btn_rise;
            end else begin
              ped_pending <= ped_pending | btn_rise;
            end
          end

          WALK: begin
            ped_pending <= ped_pending | btn_rise;
            if (!red) begin
              state     <= IDLE;
              walk      <= 1'b0;
              dont_walk <= 1'b1;
              countdown <= '0;
            end else begin
              countdown <= countdown - 8'd1;
              if (countdown == WALK_LAST) begin
                state     <= FLASH;
                walk      <= 1'b0;
                dont_walk <= 1'b1;
                blink_cnt <= '0;
              end
            end
          end

          FLASH: begin
            ped_pending <= ped_pending | btn_rise;
            if (!red || countdown == 8'd1) begin
              state     <= IDLE;
              dont_walk <= 1'b1;
              countdown <= '0;
            end else begin
              countdown <= countdown - 8'd1;
              if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                dont_walk <= ~dont_walk;
              end else begin
                blink_cnt <= blink_cnt + 1'b1;
              end
            end
          end

          FAULT: begin
            if (blink_cnt == BLINK_LAST) begin
              blink_cnt <= '0;
              dont_walk <= ~dont_walk;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed bench for ped_crossing_ctrl: reset, full crossing, late request, abort, fault and async reset.
module tb_ped_crossing_ctrl;

  logic       clk;
  logic       rst;
  logic       red;
  logic       yellow;
  logic       green;
  logic       ped_btn;
  logic       walk;
  logic       dont_walk;
  logic       ped_pending;
  logic [7:0] countdown;
  logic       fault;

  int n_checks = 0;
  int n_errors = 0;

  ped_crossing_ctrl #(
    .WALK_CYCLES (20),
    .FLASH_CYCLES(10),
    .BLINK_HALF  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .red        (red),
    .yellow     (yellow),
    .green      (green),
    .ped_btn    (ped_btn),
    .walk       (walk),
    .dont_walk  (dont_walk),
    .ped_pending(ped_pending),
    .countdown  (countdown),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic w, input logic dw, input logic p,
                           input logic [7:0] cd, input logic f);
    check({tag, ".walk"},        {7'd0, walk},        {7'd0, w});
    check({tag, ".dont_walk"},   {7'd0, dont_walk},   {7'd0, dw});
    check({tag, ".ped_pending"}, {7'd0, ped_pending}, {7'd0, p});
    check({tag, ".countdown"},   countdown,           cd);
    check({tag, ".fault"},       {7'd0, fault},       {7'd0, f});
  endtask

  task automatic lamps(input logic r, input logic y, input logic g);
    red    = r;
    yellow = y;
    green  = g;
  endtask

  initial begin
    rst     = 1'b0;
    ped_btn = 1'b0;
    lamps(1'b0, 1'b0, 1'b1);

    // T1: reset held, then released with green lamps
    repeat (5) tick();
    check_out("t1_reset", 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    check_out("t1_release", 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);

    // T2: request during green, full walk + flash sequence
    ped_btn = 1'b1;
    tick();
    check_out("t2_press", 1'b0, 1'b1, 1'b1, 8'd0, 1'b0);
    ped_btn = 1'b0;
    tick();
    lamps(1'b0, 1'b1, 1'b0);
    tick();
    lamps(1'b1, 1'b0, 1'b0);
    tick();
    check_out("t2_walk_entry", 1'b1, 1'b0, 1'b0, 8'd30, 1'b0);
    for (int i = 1; i < 20; i++) begin
      tick();
      check_out($sformatf("t2_walk%0d", i), 1'b1, 1'b0, 1'b0, 8'(30 - i), 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      check_out($sformatf("t2_flash%0d", i), 1'b0, ((i / 2) % 2) == 0, 1'b0, 8'(10 - i), 1'b0);
    end
    tick();
    check_out("t2_idle", 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);

    // T3: press while red already high waits for the next red start
    ped_btn = 1'b1;
    tick();
    check_out("t3_press", 1'b0, 1'b1, 1'b1, 8'd0, 1'b0);
    tick();
    tick();
    check_out("t3_hold", 1'b0, 1'b1, 1'b1, 8'd0, 1'b0);
    ped_btn = 1'b0;
    lamps(1'b0, 1'b0, 1'b1);
    tick();
    check_out("t3_green", 1'b0, 1'b1, 1'b1, 8'd0, 1'b0);
    lamps(1'b0, 1'b1, 1'b0);
    tick();
    lamps(1'b1, 1'b0, 1'b0);
    tick();
    check_out("t3_walk_entry", 1'b1, 1'b0, 1'b0, 8'd30, 1'b0);

    // T4: press during walk, red falls at the 5th walk clock
    ped_btn = 1'b1;
    tick();
    check_out("t4_press", 1'b1, 1'b0, 1'b1, 8'd29, 1'b0);
    ped_btn = 1'b0;
    tick();
    tick();
    tick();
    check_out("t4_walk5", 1'b1, 1'b0, 1'b1, 8'd26, 1'b0);
    lamps(1'b0, 1'b0, 1'b1);
    tick();
    check_out("t4_abort", 1'b0, 1'b1, 1'b1, 8'd0, 1'b0);

    // T6: async reset in the middle of a walk
    lamps(1'b0, 1'b1, 1'b0);
    tick();
    lamps(1'b1, 1'b0, 1'b0);
    tick();
    check_out("t6_walk_entry", 1'b1, 1'b0, 1'b0, 8'd30, 1'b0);
    repeat (13) tick();
    check_out("t6_walk_cd17", 1'b1, 1'b0, 1'b0, 8'd17, 1'b0);
    rst = 1'b0;
    #1;
    check_out("t6_async_rst", 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    lamps(1'b0, 1'b0, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    tick();

    // T5: single illegal clock ignored, two consecutive latch a sticky fault
    lamps(1'b1, 1'b1, 1'b0);
    tick();
    lamps(1'b0, 1'b0, 1'b1);
    tick();
    check_out("t5_glitch", 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    lamps(1'b1, 1'b1, 1'b0);
    tick();
    check_out("t5_illegal1", 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    tick();
    check_out("t5_fault", 1'b0, 1'b1, 1'b0, 8'd0, 1'b1);
    lamps(1'b0, 1'b0, 1'b1);
    ped_btn = 1'b1;
    tick();
    check_out("t5_blink1", 1'b0, 1'b1, 1'b0, 8'd0, 1'b1);
    ped_btn = 1'b0;
    tick();
    check_out("t5_blink2", 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    tick();
    check_out("t5_blink3", 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    tick();
    check_out("t5_blink4", 1'b0, 1'b1, 1'b0, 8'd0, 1'b1);
    rst = 1'b0;
    #1;
    check_out("t5_clear", 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
